// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// State encoding, default frame geometry and a counter-width helper.
package uart_pkg;

   localparam int DEF_DATA_SIZE  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter producing a strobe on the last tick of each serial bit.
// Held at zero by clear; wraps by itself at each bit end.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic baud_tick,
   output logic bit_end
);

   localparam int               CNT_W     = cnt_width(OVERSAMPLE);
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0] tick_cnt;

   assign bit_end = baud_tick && !clear && (tick_cnt == LAST_TICK);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (clear || bit_end) begin
         tick_cnt <= '0;
      end else if (baud_tick) begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO, frames the word and drives the line.
// Frame settings are captured at the pop so mid-frame config changes wait for the next word.
//
//   state  | meaning
//   IDLE   | line high; pops FIFO head whenever it is not empty
//   START  | start bit (line low)
//   DATA   | DATA_SIZE data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | one or two stop bits (line high)
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_SIZE  = DEF_DATA_SIZE,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_data,
   output logic                 fifo_read,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int               BIT_W    = cnt_width(DATA_SIZE);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);

   tx_state_t            state;
   logic [DATA_SIZE-1:0] shift;
   logic [DATA_SIZE-1:0] shift_nxt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 par_bit;
   logic                 par_en_q;
   logic                 stop2_q;
   logic                 stop_cnt;
   logic                 tx_q;
   logic                 bit_end;
   logic                 pop;
   logic                 last_stop;

   // Pop is combinational so the FIFO sees it in the first IDLE cycle.
   assign pop       = reset_n && (state == IDLE) && !fifo_empty;
   assign last_stop = !stop2_q || stop_cnt;
   assign shift_nxt = shift >> 1;

   assign fifo_read = pop;
   assign busy      = (state != IDLE) || pop;
   assign tx_done   = reset_n && (state == STOP) && bit_end && last_stop;
   assign tx        = tx_q;

   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (state == IDLE),
      .baud_tick(baud_tick),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         tx_q     <= 1'b1;
         shift    <= '0;
         bit_cnt  <= '0;
         par_bit  <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         stop_cnt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift    <= fifo_data;
                  par_bit  <= (^fifo_data) ^ parity_odd;
                  par_en_q <= parity_en;
                  stop2_q  <= stop2;
                  tx_q     <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_q    <= shift[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt  <= '0;
                     stop_cnt <= 1'b0;
                     if (par_en_q) begin
                        tx_q  <= par_bit;
                        state <= PARITY;
                     end else begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     shift   <= shift_nxt;
                     tx_q    <= shift_nxt[0];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  tx_q     <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (!last_stop) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     stop_cnt <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               tx_q  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frames checked bit by bit against hand-built vectors.
// A small queue stands in for the TX FIFO; outputs sampled on the falling edge.
module tb_uart_tx_ctrl;

   logic       clk;
   logic       reset_n;
   logic       baud_tick;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read;
   logic       parity_en;
   logic       parity_odd;
   logic       stop2;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic [7:0] byte_q[$];
   int         total = 0;
   int         bad   = 0;
   int         pops  = 0;

   logic s_tx, s_rd, s_busy, s_done;

   uart_tx_ctrl #(
      .DATA_SIZE (8),
      .OVERSAMPLE(16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .baud_tick (baud_tick),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_read (fifo_read),
      .parity_en (parity_en),
      .parity_odd(parity_odd),
      .stop2     (stop2),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic update_fifo();
      fifo_empty = (byte_q.size() == 0);
      fifo_data  = (byte_q.size() == 0) ? 8'h00 : byte_q[0];
   endtask

   // One clock: sample outputs at negedge, then apply the FIFO pop after the edge.
   task automatic clk_cycle(input logic tk);
      baud_tick = tk;
      @(negedge clk);
      s_tx   = tx;
      s_rd   = fifo_read;
      s_busy = busy;
      s_done = tx_done;
      @(posedge clk);
      #1;
      if (s_rd === 1'b1 && byte_q.size() != 0) begin
         void'(byte_q.pop_front());
         pops++;
      end
      update_fifo();
   endtask

   // Expects the pop in the very next cycle, then follows the frame tick by tick.
   task automatic run_frame(input string tag, input int nbits, input logic [11:0] exp_bits,
                            input int period, input int toggle_at);
      int         ticks    = 0;
      int         glitch   = 0;
      int         stray    = 0;
      int         not_busy = 0;
      int         done_at  = -1;
      int         cyc      = 0;
      int         idx;
      logic       tk;
      logic       exp_tx;
      logic [11:0] obs = '0;

      clk_cycle(1'b0);
      chk({tag, " pop"}, 32'(s_rd), 32'd1);
      chk({tag, " pop_tx"}, 32'(s_tx), 32'd1);
      chk({tag, " pop_busy"}, 32'(s_busy), 32'd1);

      while (done_at < 0 && cyc < nbits * 16 * period + 64) begin
         tk = ((cyc % period) == period - 1);
         if (cyc == toggle_at) begin
            parity_en  = !parity_en;
            parity_odd = !parity_odd;
            stop2      = !stop2;
         end
         clk_cycle(tk);
         idx    = ticks / 16;
         exp_tx = (idx < nbits) ? exp_bits[idx] : 1'b1;
         if (s_tx !== exp_tx) glitch++;
         if ((ticks % 16) == 8 && idx < 12) obs[idx] = s_tx;
         if (s_rd !== 1'b0) stray++;
         if (s_busy !== 1'b1) not_busy++;
         if (s_done === 1'b1) done_at = ticks + (tk ? 1 : 0);
         if (tk) ticks++;
         cyc++;
      end

      chk({tag, " bits"}, 32'(obs), 32'(exp_bits));
      chk({tag, " done_tick"}, 32'(done_at), 32'(nbits * 16));
      chk({tag, " tx_cycles_off"}, 32'(glitch), 32'd0);
      chk({tag, " stray_read"}, 32'(stray), 32'd0);
      chk({tag, " busy_drop"}, 32'(not_busy), 32'd0);
   endtask

   initial begin
      int p0;
      int cnt_rd;
      int cnt_tx;
      int cnt_busy;
      int ticks;

      reset_n    = 1'b0;
      baud_tick  = 1'b0;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      byte_q     = {8'hA5};
      update_fifo();

      // Reset held with a word waiting: nothing may pop.
      cnt_rd = 0;
      for (int i = 0; i < 4; i++) begin
         clk_cycle(1'b1);
         if (s_rd !== 1'b0) cnt_rd++;
      end
      chk("rst_read", 32'(cnt_rd), 32'd0);
      chk("rst_tx", 32'(s_tx), 32'd1);
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_done", 32'(s_done), 32'd0);

      reset_n = 1'b1;
      run_frame("a5_8n1", 10, 12'h34A, 1, -1);

      parity_en  = 1'b1;
      parity_odd = 1'b0;
      stop2      = 1'b1;
      byte_q.push_back(8'h07);
      update_fifo();
      run_frame("07_even_2s", 12, 12'hE0E, 3, -1);

      parity_odd = 1'b1;
      byte_q.push_back(8'h07);
      update_fifo();
      run_frame("07_odd_2s", 12, 12'hC0E, 2, -1);

      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      byte_q     = {8'h00, 8'hFF, 8'h3C};
      update_fifo();
      p0 = pops;
      run_frame("b2b_00", 10, 12'h200, 1, -1);
      run_frame("b2b_ff", 10, 12'h3FE, 1, -1);
      run_frame("b2b_3c", 10, 12'h278, 1, -1);
      chk("b2b_pops", 32'(pops - p0), 32'd3);

      cnt_rd   = 0;
      cnt_tx   = 0;
      cnt_busy = 0;
      for (int i = 0; i < 1000; i++) begin
         clk_cycle(1'($urandom_range(0, 1)));
         if (s_rd !== 1'b0) cnt_rd++;
         if (s_tx !== 1'b1) cnt_tx++;
         if (s_busy !== 1'b0) cnt_busy++;
      end
      chk("idle_read", 32'(cnt_rd), 32'd0);
      chk("idle_tx", 32'(cnt_tx), 32'd0);
      chk("idle_busy", 32'(cnt_busy), 32'd0);

      // Abort a frame during data bit 3; the popped word is lost.
      byte_q = {8'h5A, 8'hC3};
      update_fifo();
      clk_cycle(1'b0);
      chk("abort_pop", 32'(s_rd), 32'd1);
      ticks = 0;
      while (ticks < 16 * 4 + 4) begin
         clk_cycle(1'b1);
         ticks++;
      end
      chk("abort_bit3", 32'(tx), 32'd1);
      reset_n = 1'b0;
      clk_cycle(1'b1);
      chk("abort_done", 32'(s_done), 32'd0);
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      clk_cycle(1'b1);
      chk("abort_hold_read", 32'(s_rd), 32'd0);
      chk("abort_hold_done", 32'(s_done), 32'd0);
      reset_n = 1'b1;
      run_frame("abort_resume_c3", 10, 12'h386, 1, -1);

      // Config flipped mid-frame applies only to the following word.
      parity_en  = 1'b0;
      parity_odd = 1'b1;
      stop2      = 1'b0;
      byte_q     = {8'h81, 8'h81};
      update_fifo();
      run_frame("cfg_current", 10, 12'h302, 1, 30);
      run_frame("cfg_next", 12, 12'hD02, 1, -1);
      chk("cfg_fifo_drained", 32'(byte_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, 8, data bits per frame and width of the FIFO data path.
REQ-002 SHALL have parameter OVERSAMPLE, 16, number of baud_tick pulses per serial bit.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port baud_tick  input  1  one-clk-wide oversample enable from the external baud generator.
REQ-006 SHALL have port fifo_empty  input  1  TX FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  DATA_SIZE  TX FIFO head word; valid whenever fifo_empty=0, no read latency.
REQ-008 SHALL have port fifo_read  output  1  one-cycle pop strobe to the TX FIFO.
REQ-009 SHALL have port parity_en  input  1  1 = append a parity bit.
REQ-010 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-011 SHALL have port stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  high from pop cycle through end of last stop bit.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with fifo_empty=0: fifo_read=1 for exactly one cycle, fifo_data latched into shift register, parity_en/parity_odd/stop2 latched, next state START.
REQ-017 fifo_read SHALL never assert while fifo_empty=1 or outside IDLE.
REQ-018 Bit period: tick counter (width clog2(OVERSAMPLE)) counts baud_tick; bit ends on the cycle baud_tick=1 and counter=OVERSAMPLE-1; counter clears on every state entry.
REQ-019 tx SHALL be registered: 0 in START, shift[0] in DATA (LSB first, shift right per bit), parity bit in PARITY, 1 in STOP and IDLE.
REQ-020 DATA SHALL last exactly DATA_SIZE bit periods; bit counter wraps to 0 on leaving DATA.
REQ-021 Parity bit = XOR of latched byte for even, inverted for odd; PARITY skipped when latched parity_en=0.
REQ-022 STOP SHALL last 1 or 2 bit periods per latched stop2.
REQ-023 tx_done=1 for one cycle on the last STOP bit end; next state IDLE.
REQ-024 Back-to-back frames: pop occurs on the first IDLE cycle, so inter-frame gap is one clk, not one bit.
REQ-025 Config inputs changed mid-frame SHALL NOT affect the current frame.
REQ-026 baud_tick asserted on consecutive clocks SHALL each count; no tick in a state means no progress.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force state IDLE, tx=1, fifo_read=0, busy=0, tx_done=0, counters 0, shift register 0.
REQ-028 Reset mid-frame SHALL abort the frame; popped byte is discarded, no tx_done.
REQ-029 First pop after reset release SHALL be no earlier than the first edge with reset_n=1.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum typedef, default DATA_SIZE and OVERSAMPLE constants.
REQ-031 One sub-module uart_bit_timer (tick counter + bit-end strobe) is natural; the FSM, shift register and parity stay in uart_tx_ctrl.

Verification
REQ-032 Byte 0xA5, 8N1, OVERSAMPLE=16 -> one fifo_read, tx = 0,1,0,1,0,0,1,0,1,1 each 16 ticks, tx_done at tick 160.
REQ-033 Byte 0x07, even parity, stop2=1 -> parity bit 1, frame 12 bits / 192 ticks; odd parity -> parity bit 0.
REQ-034 Three bytes queued, fifo_empty low -> three pops, each exactly one clk after prior tx_done; tx never glitches low between frames.
REQ-035 fifo_empty=1 for 1000 cycles -> fifo_read stays 0, tx stays 1, busy 0.
REQ-036 reset_n low during DATA bit 3 -> next edge tx=1, busy=0, no tx_done; after release, next queued byte sent intact.
REQ-037 Toggle parity_en and stop2 mid-frame -> current frame unchanged, next frame uses new settings.
